sync_debounce: RTL and testbench

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce_pkg.sv | 25 ++
 rtl/sync_debounce_chain.sv | 35 +++
 rtl/sync_debounce.sv | 110 +++++++++++
 tb/tb_sync_debounce.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sync_debounce_pkg.sv
// Shared defaults and counter sizing for the sync_debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; level-based inputs/outputs).
//
// Contents:
//   NCH_DEF, STAGES_DEF, DEB_CYCLES_DEF : default parameter values
//   cnt_width()                         : debounce counter width for a given DEB_CYCLES
//   `SYNC_DEB_CNT_W(n)                  : same width as a text macro, for non-package users
`ifndef SYNC_DEB_CNT_W
`define SYNC_DEB_CNT_W(n) ($clog2((n) + 1))
`endif

package sync_debounce_pkg;

  localparam int NCH_DEF        = 4;
  localparam int STAGES_DEF     = 2;
  localparam int DEB_CYCLES_DEF = 16;

  // Counter must represent 0..DEB_CYCLES-1; sized on DEB_CYCLES+1 so the
  // width never collapses to zero for DEB_CYCLES == 1.
  function automatic int cnt_width(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_chain.sv
// sync_chain: 1-bit multi-flop synchronizer for one asynchronous input.
// Latency: STAGES rising edges from a stable d to q.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous raw input
//   q     : synchronized sample (last stage)
module sync_chain
  import sync_debounce_pkg::*;
#(
  parameter int STAGES = STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Keep the stages together and away from retiming so the first flop has a
  // full cycle to resolve metastability.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: per-channel synchronizer + debounce filter with edge pulses.
// Latency: STAGES+DEB_CYCLES edges to sync_out (STAGES+1 without SYNC_DEBOUNCE_EN); rise/fall one edge later.
// Backpressure: none; outputs are levels/pulses, consumer must sample every cycle.
//
// Build option: define SYNC_DEBOUNCE_EN to enable the debounce counter; when
// undefined, sync_out is the synchronized sample registered once and
// DEB_CYCLES only takes part in the parameter range check.
//
// Ports:
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   async_in : NCH raw asynchronous inputs
//   sync_out : NCH synchronized (and debounced) levels
//   rise     : NCH one-cycle pulses, cycle after sync_out goes 0->1
//   fall     : NCH one-cycle pulses, cycle after sync_out goes 1->0
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] async_in,
  output logic [NCH-1:0] sync_out,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall
);

  // Elaboration-time parameter range checks.
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("sync_debounce: NCH out of range 1..32");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_debounce: STAGES out of range 2..4");
  end
  if (DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("sync_debounce: DEB_CYCLES out of range 1..65535");
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic s;        // synchronized sample
    logic lvl;      // accepted level, drives sync_out
    logic lvl_prev; // lvl one edge ago, for registered edge pulses
    logic rise_q;
    logic fall_q;

    sync_chain #(
      .STAGES (STAGES)
    ) u_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (async_in[g]),
      .q     (s)
    );

`ifdef SYNC_DEBOUNCE_EN
    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // cnt counts consecutive edges on which s disagreed with lvl. Any
    // agreement (including a glitch returning) restarts it; reaching
    // CNT_LAST commits the new level, so cnt never exceeds CNT_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        lvl <= s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl <= 1'b0;
      end else begin
        lvl <= s;
      end
    end
`endif

    // Pulses are derived from the already-registered level, so they land
    // one edge after the sync_out transition; the two terms are mutually
    // exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_prev <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        lvl_prev <= lvl;
        rise_q   <= lvl & ~lvl_prev;
        fall_q   <= ~lvl & lvl_prev;
      end
    end

    assign sync_out[g] = lvl;
    assign rise[g]     = rise_q;
    assign fall[g]     = fall_q;
  end

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

  localparam int NCH    = 4;
  localparam int STAGES = 2;
  localparam int DEB    = 16;
`ifdef SYNC_DEBOUNCE_EN
  localparam int LAT = STAGES + DEB;
`else
  localparam int LAT = STAGES + 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] async_in = '0;
  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;

  sync_debounce #(
    .NCH        (NCH),
    .STAGES     (STAGES),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (async_in),
    .sync_out (sync_out),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs delayed by STAGES samples give s; the output
  // level adopts a value once the last DEB samples of s all carry it.
  logic [NCH-1:0] in_q[$];
  logic [NCH-1:0] s_q[$];
  logic [NCH-1:0] m_out, m_prev, m_rise, m_fall;

  task automatic model_reset();
    in_q = {};
    s_q  = {};
    for (int i = 0; i < STAGES; i++) in_q.push_back('0);
    for (int i = 0; i < DEB; i++) s_q.push_back('0);
    m_out  = '0;
    m_prev = '0;
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] s_pre, all1, any1;
    s_pre = in_q.pop_front();
    in_q.push_back(async_in);
    s_q.push_back(s_pre);
    void'(s_q.pop_front());
    all1 = '1;
    any1 = '0;
    foreach (s_q[i]) begin
      all1 &= s_q[i];
      any1 |= s_q[i];
    end
    m_rise = m_out & ~m_prev;
    m_fall = ~m_out & m_prev;
    m_prev = m_out;
`ifdef SYNC_DEBOUNCE_EN
    m_out = all1 | (m_out & any1);
`else
    m_out = s_pre;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("sync_out", 32'(sync_out), 32'(m_out));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("rise_fall_excl", 32'(rise & fall), 32'd0);
  endtask

  logic seen;
  int   toggle_div;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_sync_out", 32'(sync_out), 32'd0);
    check("reset_rise", 32'(rise), 32'd0);
    check("reset_fall", 32'(fall), 32'd0);
    rst_n = 1'b1;

    // Clean step on channel 0.
    async_in = 4'b0001;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == LAT - 1) check("t1_before_lat", 32'(sync_out[0]), 32'd0);
      if (e == LAT)     check("t1_at_lat", 32'(sync_out[0]), 32'd1);
      if (e == LAT + 1) check("t1_rise", 32'(rise[0]), 32'd1);
      if (e == LAT + 2) check("t1_rise_gone", 32'(rise[0]), 32'd0);
      if (e == LAT)     check("t1_others", 32'(sync_out[3:1]), 32'd0);
    end

    // 10-cycle glitch on channel 1.
    seen = 1'b0;
    async_in[1] = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (e == 10) async_in[1] = 1'b0;
      tick();
      seen |= sync_out[1] | rise[1] | fall[1];
    end
`ifdef SYNC_DEBOUNCE_EN
    check("t2_glitch_filtered", 32'(seen), 32'd0);
`else
    check("t2_glitch_passes", 32'(seen), 32'd1);
`endif

    // Bounce 1,0,1 (3 cycles each) then steady high on channel 2.
    async_in[2] = 1'b1;
    repeat (3) tick();
    async_in[2] = 1'b0;
    repeat (3) tick();
    async_in[2] = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      if (e == LAT - 1) check("t3_before_lat", 32'(sync_out[2]), 32'd0);
      if (e == LAT)     check("t3_at_lat", 32'(sync_out[2]), 32'd1);
    end

    // Steady high on channel 3, then a one-cycle reset pulse.
    async_in[3] = 1'b1;
    repeat (LAT + 4) tick();
    check("t4_pre_reset", 32'(sync_out[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_reset_sync_out", 32'(sync_out), 32'd0);
    check("t4_reset_rise", 32'(rise), 32'd0);
    check("t4_reset_fall", 32'(fall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= LAT + 3; e++) begin
      tick();
      if (e == LAT)     check("t4_rise_early", 32'(rise[3]), 32'd0);
      if (e == LAT + 1) check("t4_rise", 32'(rise[3]), 32'd1);
      if (e == LAT + 2) check("t4_rise_once", 32'(rise[3]), 32'd0);
    end

    // Single-cycle pulse on channel 0 (currently high: pulse low).
    seen = 1'b0;
    async_in[0] = 1'b0;
    tick();
    async_in[0] = 1'b1;
    for (int e = 0; e < LAT + 4; e++) begin
      tick();
      seen |= fall[0];
    end
`ifdef SYNC_DEBOUNCE_EN
    check("t5_pulse_filtered", 32'(seen), 32'd0);
`else
    check("t5_pulse_passes", 32'(seen), 32'd1);
`endif

    // Random stimulus; toggle rate varies by phase so both filtered
    // glitches and accepted levels occur.
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) toggle_div = $urandom_range(2, 40);
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, toggle_div - 1) == 0) async_in[ch] = ~async_in[ch];
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
